// File: rtl/pspin_her_gen_pipe_if.sv
// -----------------------------------------------------------------------------
// pspin_her_gen_pipe_if
//   Bundles the two streams that pass through the HER generator:
//     gen_*  : ingress DMA completion (valid/ready, addr, len, tag)
//     her_*  : handler execution request towards the PsPIN wrapper
//   Modports:
//     master : environment side, drives completions and consumes HERs
//     slave  : generator side, accepts completions and produces HERs
// -----------------------------------------------------------------------------
interface pspin_her_gen_pipe_if #(
   parameter int NUM_CTX        = 4,
   parameter int C_MSGID_WIDTH  = 10,
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int LEN_WIDTH      = 20,
   parameter int TAG_WIDTH      = 32,
   parameter int CTX_META_WIDTH = 768
);
   localparam int CTX_ID_WIDTH = $clog2(NUM_CTX);

   logic                      gen_valid;
   logic                      gen_ready;
   logic [AXI_ADDR_WIDTH-1:0] gen_addr;
   logic [LEN_WIDTH-1:0]      gen_len;
   logic [TAG_WIDTH-1:0]      gen_tag;

   logic                      her_valid;
   logic                      her_ready;
   logic [C_MSGID_WIDTH-1:0]  her_msgid;
   logic                      her_is_eom;
   logic [CTX_ID_WIDTH-1:0]   her_ctx_id;
   logic [AXI_ADDR_WIDTH-1:0] her_addr;
   logic [AXI_ADDR_WIDTH-1:0] her_size;
   logic [AXI_ADDR_WIDTH-1:0] her_xfer_size;
   logic [CTX_META_WIDTH-1:0] her_meta;

   modport master (
      output gen_valid, gen_addr, gen_len, gen_tag, her_ready,
      input  gen_ready, her_valid, her_msgid, her_is_eom, her_ctx_id,
             her_addr, her_size, her_xfer_size, her_meta
   );

   modport slave (
      input  gen_valid, gen_addr, gen_len, gen_tag, her_ready,
      output gen_ready, her_valid, her_msgid, her_is_eom, her_ctx_id,
             her_addr, her_size, her_xfer_size, her_meta
   );
endinterface

// File: rtl/pspin_her_gen_pipe.sv
// -----------------------------------------------------------------------------
// pspin_her_gen_pipe
//   Pipelined HER generator between ingress DMA completion and the PsPIN
//   wrapper. A completion tag {.., msgid, is_eom, ctx_id} is decoded, the
//   per-context metadata is selected (disabled contexts fall back to ctx 0),
//   the transfer size is clamped to MAX_XFER_SIZE and the resulting HER is
//   held in a 2-entry skid buffer whose head drives the her_* outputs.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   conf_valid          one-cycle pulse latching conf_meta / conf_ctx_enabled
//   conf_meta           context i metadata at [i*CTX_META_WIDTH +: CTX_META_WIDTH]
//   conf_ctx_enabled    per-context enable bitmap
//   bus (slave)         gen_* completion stream in, her_* request stream out
//   stat_sel            (HER_GEN_STATS_EN) context selected for stat_her_count
//   stat_her_count      (HER_GEN_STATS_EN) HERs popped for stat_sel, 1-cycle latency
//   stat_fallback_count (HER_GEN_STATS_EN) completions that fell back to ctx 0
//
// Optional feature: define HER_GEN_STATS_EN to add the statistics counters
// and ports. Without it the datapath is identical and no counters exist.
// -----------------------------------------------------------------------------
module pspin_her_gen_pipe #(
   parameter int NUM_CTX        = 4,
   parameter int C_MSGID_WIDTH  = 10,
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int LEN_WIDTH      = 20,
   parameter int TAG_WIDTH      = 32,
   parameter int CTX_META_WIDTH = 768,
   parameter int MAX_XFER_SIZE  = 1024,
   localparam int CTX_ID_WIDTH  = $clog2(NUM_CTX)
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              conf_valid,
   input  logic [NUM_CTX*CTX_META_WIDTH-1:0] conf_meta,
   input  logic [NUM_CTX-1:0]                conf_ctx_enabled,
   pspin_her_gen_pipe_if.slave               bus
`ifdef HER_GEN_STATS_EN
   ,
   input  logic [CTX_ID_WIDTH-1:0]           stat_sel,
   output logic [31:0]                       stat_her_count,
   output logic [31:0]                       stat_fallback_count
`endif
);

   localparam int TAG_USED = C_MSGID_WIDTH + 1 + CTX_ID_WIDTH;
   localparam logic [AXI_ADDR_WIDTH-1:0] MAX_XFER = AXI_ADDR_WIDTH'(MAX_XFER_SIZE);

   if (NUM_CTX < 2 || (NUM_CTX & (NUM_CTX - 1)) != 0) begin : g_bad_num_ctx
      $error("NUM_CTX must be a power of 2 and at least 2");
   end
   if (TAG_WIDTH < TAG_USED) begin : g_bad_tag_width
      $error("TAG_WIDTH too small for {msgid, is_eom, ctx_id}");
   end
   if (LEN_WIDTH > AXI_ADDR_WIDTH) begin : g_bad_len_width
      $error("LEN_WIDTH must not exceed AXI_ADDR_WIDTH");
   end

   typedef struct packed {
      logic [C_MSGID_WIDTH-1:0]  msgid;
      logic                      is_eom;
      logic [CTX_ID_WIDTH-1:0]   ctx_id;
      logic [AXI_ADDR_WIDTH-1:0] addr;
      logic [AXI_ADDR_WIDTH-1:0] size;
      logic [AXI_ADDR_WIDTH-1:0] xfer_size;
      logic [CTX_META_WIDTH-1:0] meta;
   } her_t;

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_FULL  = 2'd2
   } state_t;

   // Saturate the completion length to the largest transfer the wrapper takes.
   function automatic logic [AXI_ADDR_WIDTH-1:0] clamp_xfer(input logic [LEN_WIDTH-1:0] len);
      logic [AXI_ADDR_WIDTH-1:0] len_ext;
      len_ext = AXI_ADDR_WIDTH'(len);
      return (len_ext > MAX_XFER) ? MAX_XFER : len_ext;
   endfunction

   state_t                                   state_q, state_d;
   her_t                                     head_q, head_d;
   her_t                                     tail_q, tail_d;
   logic [NUM_CTX-1:0]                       en_q, en_d;
   logic [NUM_CTX-1:0][CTX_META_WIDTH-1:0]   meta_q, meta_d;

   logic [CTX_ID_WIDTH-1:0]  tag_ctx;
   logic                     tag_eom;
   logic [C_MSGID_WIDTH-1:0] tag_msgid;
   logic                     ctx_en;
   logic [CTX_ID_WIDTH-1:0]  eff_ctx;
   logic                     gen_ready;
   logic                     her_valid;
   logic                     accept;
   logic                     pop;
   her_t                     new_her;

   // Tag bits above {msgid, is_eom, ctx_id} carry no meaning here.
   if (TAG_WIDTH > TAG_USED) begin : g_tag_hi
      logic unused_tag_hi;
      assign unused_tag_hi = ^bus.gen_tag[TAG_WIDTH-1:TAG_USED];
   end

   // ---- decode stage: completion -> candidate HER ----
   assign tag_ctx   = bus.gen_tag[CTX_ID_WIDTH-1:0];
   assign tag_eom   = bus.gen_tag[CTX_ID_WIDTH];
   assign tag_msgid = bus.gen_tag[CTX_ID_WIDTH+1 +: C_MSGID_WIDTH];
   assign ctx_en    = en_q[tag_ctx];
   assign eff_ctx   = ctx_en ? tag_ctx : '0;

   // Context 0 is the fallback target, so nothing is accepted without it.
   assign gen_ready = en_q[0] && (state_q != S_FULL);
   assign her_valid = (state_q != S_EMPTY);
   assign accept    = bus.gen_valid && gen_ready;
   assign pop       = her_valid && bus.her_ready;

   always_comb begin
      new_her           = '0;
      new_her.msgid     = tag_msgid;
      new_her.is_eom    = tag_eom;
      new_her.ctx_id    = eff_ctx;
      new_her.addr      = bus.gen_addr;
      new_her.size      = AXI_ADDR_WIDTH'(bus.gen_len);
      new_her.xfer_size = clamp_xfer(bus.gen_len);
      // Metadata is captured at acceptance so later reconfiguration never
      // alters an already buffered HER.
      new_her.meta      = meta_q[eff_ctx];
   end

   always_comb begin
      en_d   = conf_valid ? conf_ctx_enabled : en_q;
      meta_d = conf_valid ? conf_meta : meta_q;
   end

   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      tail_d  = tail_q;
      unique case (state_q)
         S_EMPTY: begin
            if (accept) begin
               head_d  = new_her;
               state_d = S_ONE;
            end
         end
         S_ONE: begin
            if (accept && !pop) begin
               tail_d  = new_her;
               state_d = S_FULL;
            end else if (pop && !accept) begin
               state_d = S_EMPTY;
            end else if (accept && pop) begin
               head_d  = new_her;
            end
         end
         S_FULL: begin
            if (pop) begin
               head_d  = tail_q;
               state_d = S_ONE;
            end
         end
         default: state_d = S_EMPTY;
      endcase
   end

   // ---- skid stage: registered head drives the HER outputs ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_EMPTY;
         head_q  <= '0;
         tail_q  <= '0;
         en_q    <= '0;
         meta_q  <= '0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         en_q    <= en_d;
         meta_q  <= meta_d;
      end
   end

   assign bus.gen_ready     = gen_ready;
   assign bus.her_valid     = her_valid;
   assign bus.her_msgid     = head_q.msgid;
   assign bus.her_is_eom    = head_q.is_eom;
   assign bus.her_ctx_id    = head_q.ctx_id;
   assign bus.her_addr      = head_q.addr;
   assign bus.her_size      = head_q.size;
   assign bus.her_xfer_size = head_q.xfer_size;
   assign bus.her_meta      = head_q.meta;

`ifdef HER_GEN_STATS_EN
   logic [NUM_CTX-1:0][31:0] her_cnt_q, her_cnt_d;
   logic [31:0]              fb_cnt_q, fb_cnt_d;
   logic [31:0]              stat_her_q, stat_her_d;
   logic [31:0]              stat_fb_q, stat_fb_d;

   always_comb begin
      her_cnt_d = her_cnt_q;
      if (pop) begin
         her_cnt_d[head_q.ctx_id] = her_cnt_q[head_q.ctx_id] + 32'd1;
      end
      fb_cnt_d   = fb_cnt_q + 32'(accept && !ctx_en);
      stat_her_d = her_cnt_q[stat_sel];
      stat_fb_d  = fb_cnt_q;
   end

   // ---- stats stage: counters and registered readout ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         her_cnt_q  <= '0;
         fb_cnt_q   <= '0;
         stat_her_q <= '0;
         stat_fb_q  <= '0;
      end else begin
         her_cnt_q  <= her_cnt_d;
         fb_cnt_q   <= fb_cnt_d;
         stat_her_q <= stat_her_d;
         stat_fb_q  <= stat_fb_d;
      end
   end

   assign stat_her_count      = stat_her_q;
   assign stat_fallback_count = stat_fb_q;
`endif

endmodule

// File: tb/tb_pspin_her_gen_pipe.sv
module tb_pspin_her_gen_pipe;
   localparam int NUM_CTX = 4;
   localparam int MW      = 10;
   localparam int AW      = 32;
   localparam int LW      = 20;
   localparam int TW      = 32;
   localparam int CMW     = 768;
   localparam int MAXX    = 1024;
   localparam int CW      = $clog2(NUM_CTX);

   typedef logic [1023:0] cv_t;

   typedef struct {
      logic [MW-1:0]  msgid;
      logic           eom;
      logic [CW-1:0]  ctx;
      logic [AW-1:0]  addr;
      logic [AW-1:0]  size;
      logic [AW-1:0]  xfer;
      logic [CMW-1:0] meta;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic conf_valid;
   logic [NUM_CTX*CMW-1:0] conf_meta;
   logic [NUM_CTX-1:0]     conf_ctx_enabled;

   always #5 clk = ~clk;

   pspin_her_gen_pipe_if #(
      .NUM_CTX(NUM_CTX), .C_MSGID_WIDTH(MW), .AXI_ADDR_WIDTH(AW),
      .LEN_WIDTH(LW), .TAG_WIDTH(TW), .CTX_META_WIDTH(CMW)
   ) bus ();

`ifdef HER_GEN_STATS_EN
   logic [CW-1:0] stat_sel;
   logic [31:0]   stat_her_count;
   logic [31:0]   stat_fallback_count;
   initial stat_sel = '0;
`endif

   pspin_her_gen_pipe #(
      .NUM_CTX(NUM_CTX), .C_MSGID_WIDTH(MW), .AXI_ADDR_WIDTH(AW),
      .LEN_WIDTH(LW), .TAG_WIDTH(TW), .CTX_META_WIDTH(CMW), .MAX_XFER_SIZE(MAXX)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .conf_valid       (conf_valid),
      .conf_meta        (conf_meta),
      .conf_ctx_enabled (conf_ctx_enabled),
      .bus              (bus)
`ifdef HER_GEN_STATS_EN
      ,
      .stat_sel            (stat_sel),
      .stat_her_count      (stat_her_count),
      .stat_fallback_count (stat_fallback_count)
`endif
   );

   int tests = 0;
   int fails = 0;
   int pops  = 0;
   exp_t exp_q[$];
   logic [NUM_CTX-1:0] m_en;
   logic [CMW-1:0]     m_meta [NUM_CTX];

   task automatic check(input string tag, input cv_t obs, input cv_t exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [CMW-1:0] meta_pat(input int c, input int ver);
      logic [31:0] w;
      w = 32'hA500_0000 | (32'(c) << 8) | 32'(ver);
      return {24{w}};
   endfunction

   // Reference model and scoreboard, sampled mid-cycle when all signals are settled.
   always @(negedge clk) begin
      exp_t e;
      logic [CW-1:0] tc;
      if (rst) begin
         exp_q.delete();
         m_en = '0;
         for (int i = 0; i < NUM_CTX; i++) m_meta[i] = '0;
      end else begin
         check("gen_ready", cv_t'(bus.gen_ready), cv_t'(m_en[0] && (exp_q.size() < 2)));
         check("her_valid", cv_t'(bus.her_valid), cv_t'(exp_q.size() != 0));
         if (bus.her_valid && bus.her_ready && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            pops++;
            check("her_msgid", cv_t'(bus.her_msgid),     cv_t'(e.msgid));
            check("her_eom",   cv_t'(bus.her_is_eom),    cv_t'(e.eom));
            check("her_ctx",   cv_t'(bus.her_ctx_id),    cv_t'(e.ctx));
            check("her_addr",  cv_t'(bus.her_addr),      cv_t'(e.addr));
            check("her_size",  cv_t'(bus.her_size),      cv_t'(e.size));
            check("her_xfer",  cv_t'(bus.her_xfer_size), cv_t'(e.xfer));
            check("her_meta",  cv_t'(bus.her_meta),      cv_t'(e.meta));
         end
         if (bus.gen_valid && bus.gen_ready) begin
            tc      = bus.gen_tag[CW-1:0];
            e.ctx   = m_en[tc] ? tc : '0;
            e.meta  = m_meta[e.ctx];
            e.eom   = bus.gen_tag[CW];
            e.msgid = bus.gen_tag[CW+1 +: MW];
            e.addr  = bus.gen_addr;
            e.size  = AW'(bus.gen_len);
            e.xfer  = (bus.gen_len > LW'(MAXX)) ? AW'(MAXX) : AW'(bus.gen_len);
            exp_q.push_back(e);
         end
         if (conf_valid) begin
            m_en = conf_ctx_enabled;
            for (int i = 0; i < NUM_CTX; i++) m_meta[i] = conf_meta[i*CMW +: CMW];
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_conf(input logic [NUM_CTX-1:0] en, input int v1);
      conf_ctx_enabled = en;
      for (int i = 0; i < NUM_CTX; i++) conf_meta[i*CMW +: CMW] = meta_pat(i, (i == 1) ? v1 : 0);
      conf_valid = 1'b1;
      tick();
      conf_valid = 1'b0;
   endtask

   task automatic present(input logic [MW-1:0] msgid, input logic eom, input logic [CW-1:0] ctx,
                          input logic [AW-1:0] addr, input logic [LW-1:0] len);
      logic [TW-1:0] tag;
      tag = '0;
      tag[CW-1:0]       = ctx;
      tag[CW]           = eom;
      tag[CW+1 +: MW]   = msgid;
      tag[TW-1:CW+1+MW] = (TW-CW-1-MW)'($urandom());
      bus.gen_tag   = tag;
      bus.gen_addr  = addr;
      bus.gen_len   = len;
      bus.gen_valid = 1'b1;
   endtask

   task automatic wait_accept();
      logic acc;
      acc = 1'b0;
      for (int n = 0; n < 50 && !acc; n++) begin
         @(negedge clk);
         acc = bus.gen_ready;
         tick();
      end
      check("accept_within_budget", cv_t'(acc), cv_t'(1));
   endtask

   task automatic send(input logic [MW-1:0] msgid, input logic eom, input logic [CW-1:0] ctx,
                       input logic [AW-1:0] addr, input logic [LW-1:0] len);
      present(msgid, eom, ctx, addr, len);
      wait_accept();
      bus.gen_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int pops0;
      conf_valid       = 1'b0;
      conf_meta        = '0;
      conf_ctx_enabled = '0;
      bus.gen_valid    = 1'b0;
      bus.gen_addr     = '0;
      bus.gen_len      = '0;
      bus.gen_tag      = '0;
      bus.her_ready    = 1'b1;

      // reset state
      repeat (2) tick();
      check("rst_her_valid", cv_t'(bus.her_valid), cv_t'(0));
      check("rst_gen_ready", cv_t'(bus.gen_ready), cv_t'(0));
      check("rst_her_xfer",  cv_t'(bus.her_xfer_size), cv_t'(0));
      check("rst_her_meta",  cv_t'(bus.her_meta), cv_t'(0));
      rst = 1'b0;
      tick();

      // 1: basic decode, latency 1
      do_conf(4'b0011, 0);
      send(10'd5, 1'b1, 2'd1, 32'h1000_0040, 20'd64);
      check("t1_valid", cv_t'(bus.her_valid), cv_t'(1));
      check("t1_msgid", cv_t'(bus.her_msgid), cv_t'(5));
      check("t1_eom",   cv_t'(bus.her_is_eom), cv_t'(1));
      check("t1_ctx",   cv_t'(bus.her_ctx_id), cv_t'(1));
      check("t1_xfer",  cv_t'(bus.her_xfer_size), cv_t'(64));
      check("t1_meta",  cv_t'(bus.her_meta), cv_t'(meta_pat(1, 0)));
      tick();

      // 2: disabled context falls back to ctx 0
      do_conf(4'b0001, 0);
      send(10'd7, 1'b0, 2'd3, 32'h2000_0000, 20'd128);
      check("t2_ctx",  cv_t'(bus.her_ctx_id), cv_t'(0));
      check("t2_meta", cv_t'(bus.her_meta), cv_t'(meta_pat(0, 0)));
      tick();

      // 3: ctx 0 disabled stalls without dropping
      do_conf(4'b0000, 0);
      pops0 = pops;
      present(10'd9, 1'b1, 2'd2, 32'h3000_0000, 20'd32);
      repeat (10) tick();
      check("t3_stall_no_her", cv_t'(bus.her_valid), cv_t'(0));
      do_conf(4'b0001, 0);
      wait_accept();
      bus.gen_valid = 1'b0;
      repeat (2) tick();
      check("t3_one_her", cv_t'(pops), cv_t'(pops0 + 1));

      // 5: size clamp boundaries
      do_conf(4'b0011, 0);
      send(10'd40, 1'b0, 2'd1, 32'h4000_0000, 20'd4096);
      check("t5_size", cv_t'(bus.her_size), cv_t'(4096));
      check("t5_xfer", cv_t'(bus.her_xfer_size), cv_t'(1024));
      send(10'd41, 1'b0, 2'd1, 32'h4000_1000, 20'd1024);
      check("t5_xfer_eq", cv_t'(bus.her_xfer_size), cv_t'(1024));
      send(10'd42, 1'b1, 2'd0, 32'h4000_2000, 20'd1025);
      send(10'd43, 1'b1, 2'd0, 32'h4000_3000, 20'd0);
      check("t5_xfer_zero", cv_t'(bus.her_xfer_size), cv_t'(0));
      tick();

      // 4: backpressure, skid fills, in-order drain
      bus.her_ready = 1'b0;
      send(10'd30, 1'b0, 2'd1, 32'h5000_0000, 20'd100);
      send(10'd31, 1'b1, 2'd0, 32'h5000_0100, 20'd200);
      present(10'd32, 1'b0, 2'd1, 32'h5000_0200, 20'd300);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t4_full_ready", cv_t'(bus.gen_ready), cv_t'(0));
         check("t4_hold_msgid", cv_t'(bus.her_msgid), cv_t'(30));
         check("t4_hold_len",   cv_t'(bus.her_size), cv_t'(100));
      end
      bus.her_ready = 1'b1;
      wait_accept();
      bus.gen_valid = 1'b0;
      repeat (3) tick();
      check("t4_drained", cv_t'(exp_q.size()), cv_t'(0));

      // 6: reconfiguration does not touch buffered HERs
      bus.her_ready = 1'b0;
      send(10'd20, 1'b0, 2'd1, 32'h6000_0000, 20'd16);
      do_conf(4'b0011, 1);
      check("t6_old_meta", cv_t'(bus.her_meta), cv_t'(meta_pat(1, 0)));
      send(10'd21, 1'b1, 2'd1, 32'h6000_0100, 20'd16);
      bus.her_ready = 1'b1;
      repeat (3) tick();
      check("t6_drained", cv_t'(exp_q.size()), cv_t'(0));

      // asynchronous reset with a buffered HER
      bus.her_ready = 1'b0;
      send(10'd50, 1'b1, 2'd1, 32'h7000_0000, 20'd8);
      check("rst_mid_valid_before", cv_t'(bus.her_valid), cv_t'(1));
      #2;
      rst = 1'b1;
      #1;
      check("rst_mid_valid", cv_t'(bus.her_valid), cv_t'(0));
      check("rst_mid_msgid", cv_t'(bus.her_msgid), cv_t'(0));
      tick();
      rst = 1'b0;
      bus.her_ready = 1'b1;
      tick();
      check("rst_mid_enables_cleared", cv_t'(bus.gen_ready), cv_t'(0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
